// File: rtl/kamacore_regfile_sb.sv
// Multi-ported register file with per-register busy scoreboard.
// Reads, busy lookups and reservation acceptance are combinational; state updates on clk.
module kamacore_regfile_sb #(
  parameter int XLEN     = 32,
  parameter int AW       = 5,
  parameter int NR       = 2,
  parameter int NW       = 1,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NR*AW-1:0]   rd_addr,
  output logic [NR*XLEN-1:0] rd_data,
  output logic [NR-1:0]      rd_busy,
  input  logic [NW-1:0]      wr_en,
  input  logic [NW*AW-1:0]   wr_addr,
  input  logic [NW*XLEN-1:0] wr_data,
  input  logic               rsv_en,
  input  logic [AW-1:0]      rsv_addr,
  output logic               rsv_ok,
  input  logic               flush
);

  localparam int NREG = 1 << AW;

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic [NREG-1:0] wr_hit;
  logic            rsv_set_ok;

  // Ports are scanned in ascending order so the highest-indexed matching
  // port overwrites earlier ones; regs_d doubles as the bypass source.
  always_comb begin
    for (int a = 0; a < NREG; a++) begin
      regs_d[a] = regs_q[a];
      wr_hit[a] = 1'b0;
      for (int p = 0; p < NW; p++) begin
        if (wr_en[p] && (wr_addr[p*AW +: AW] == AW'(a))) begin
          wr_hit[a] = 1'b1;
          regs_d[a] = wr_data[p*XLEN +: XLEN];
        end
      end
    end
    if (ZERO_REG != 0) begin
      regs_d[0] = '0;
    end
  end

  assign rsv_ok = rsv_en && !flush && (!busy_q[rsv_addr] || wr_hit[rsv_addr]);

  // Register 0 accepts reservations but never records them when hardwired.
  assign rsv_set_ok = rsv_ok && !((ZERO_REG != 0) && (rsv_addr == '0));

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_busy
      always_comb begin
        busy_d[gi] = busy_q[gi];
        if (wr_hit[gi]) begin
          busy_d[gi] = 1'b0;
        end
        if (rsv_set_ok && (rsv_addr == AW'(gi))) begin
          busy_d[gi] = 1'b1;
        end
        if (flush) begin
          busy_d[gi] = 1'b0;
        end
      end
    end

    for (gi = 0; gi < NR; gi++) begin : g_rd
      logic [AW-1:0]   ra;
      logic [XLEN-1:0] rv;
      assign ra = rd_addr[gi*AW +: AW];
      assign rv = (BYPASS != 0) ? regs_d[ra] : regs_q[ra];
      assign rd_data[gi*XLEN +: XLEN] =
        ((ZERO_REG != 0) && (ra == '0)) ? '0 : rv;
      assign rd_busy[gi] = busy_q[ra] && !((BYPASS != 0) && wr_hit[ra]);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int a = 0; a < NREG; a++) begin
        regs_q[a] <= '0;
      end
      busy_q <= '0;
    end else begin
      for (int a = 0; a < NREG; a++) begin
        regs_q[a] <= regs_d[a];
      end
      busy_q <= busy_d;
    end
  end

endmodule
